uart_bus_bridge: RTL and testbench
==================================

# uart_bus_bridge

UART-to-bus command bridge: the host-facing counterpart of the memory-mapped UART peripheral. It receives framed command packets on a serial line (8N1) and acts as a bus initiator, issuing single 32-bit reads and writes. Responses go back over its own TX line. It sits beside the core as a second bus master for debug and program download, behind the bus arbiter.

## Interface
- `BAUD_DIV`, default 16'd433: bit period is BAUD_DIV+1 clk cycles (434 gives 115200 bps at 50 MHz).
- `TIMEOUT`, default 32'd5_000_000: idle clk cycles allowed between bytes of one packet.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `rx_pin`  in  1  serial input, idle high, asynchronous.
- `tx_pin`  out  1  serial output, idle high.
- `req_o`  out  1  bus request, held until granted.
- `we_o`  out  1  1 = write, 0 = read; valid while req_o.
- `addr_o`  out  32  bus address; valid while req_o.
- `wdata_o`  out  32  write data; valid while req_o && we_o.
- `gnt_i`  in  1  bus grant; the transfer completes in the cycle req_o && gnt_i.
- `rdata_i`  in  32  read data; sampled in the grant cycle.
- `busy_o`  out  1  high whenever the parser is not in P_CMD.

## Operation
- **Packet formats**:
  - Write: 0x57, addr[4 bytes], data[4 bytes].
  - Read: 0x52, addr[4 bytes].
  - All multi-byte fields are little-endian (LSB byte first).
- **Responses**:
  - Write: 0x06 (ACK).
  - Read: 4 data bytes, little-endian.
  - Unknown command byte: 0x15 (NAK), then back to P_CMD.
- **RX**:
  - rx_pin passes through a 2-flop synchronizer (reset value 1).
  - A falling edge in RX idle starts a frame.
  - The start bit is re-checked at half period ((BAUD_DIV+1)>>1 cycles). If it is high, the frame is a glitch: discard it and return to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - The stop bit is sampled; if it is 0 (framing error), discard the byte.
  - A valid byte produces a 1-cycle rx_valid pulse with rx_byte.
- **Parser FSM**:
  - P_CMD: wait for a byte. 0x57 or 0x52 → P_ADDR with idx=0. Any other byte → P_RESP with a 1-byte NAK.
  - P_ADDR: shift bytes into addr; after 4 bytes go to P_DATA (write) or P_BUS (read).
  - P_DATA: shift 4 bytes into wdata → P_BUS.
  - P_BUS: req_o=1. On gnt_i, capture rdata_i for reads → P_RESP. A write response is 1 byte; a read response is 4 bytes.
  - P_RESP: send the response bytes in order → P_CMD after the last stop bit completes.
- **TX**: start bit, 8 data bits LSB first, 1 stop bit. Each bit lasts BAUD_DIV+1 cycles. The next byte starts in the cycle after the previous stop bit ends.
- **Timeout**: in P_ADDR or P_DATA, a counter runs and clears on every rx_valid. Reaching TIMEOUT returns to P_CMD silently. Partial addr/data are discarded.
- Bytes received in P_BUS or P_RESP are dropped.
- **Reset values**: tx_pin=1, req_o=0, we_o=0, addr_o=0, wdata_o=0, busy_o=0. The parser resets to P_CMD and RX/TX to idle.

## Timing
- **Byte receive**: rx_valid fires 2 (synchronizer) + 9.5 bit periods after the falling edge, give or take one cycle.
- **Bus request**: req_o rises the cycle after the final addr/data byte's rx_valid. addr_o/we_o/wdata_o are registered and stable from that cycle until grant.
- **Grant**: if gnt_i is already high, the transfer completes in 1 cycle; there is no upper bound on the wait. req_o drops the cycle after grant.
- **Response start**: the TX start bit begins the cycle after the grant cycle.
- **Back-to-back**: a new command byte is accepted once P_CMD is re-entered. The host must wait for the full response before sending.
- **Reset mid-operation**:
  - tx_pin returns to 1 the next cycle.
  - Any byte in flight is lost.
  - req_o drops with no completion.

## Structure
- **Shared package `uart_bridge_pkg`**:
  - command codes CMD_WR=8'h57, CMD_RD=8'h52;
  - response codes RSP_ACK=8'h06, RSP_NAK=8'h15;
  - parser state encodings.
- **Sub-module `uart_byte_rx`**: synchronizer, start check, bit sampling, framing check. Ports: clk, rst, rx_pin, div → rx_valid, rx_byte.
- The TX serializer and the parser live in the top.

## Test plan
Use BAUD_DIV=7 (8 cycles/bit) and TIMEOUT=200.
- **Write**: send 57 10 00 00 20 EF BE AD DE with gnt_i tied high → one cycle with req_o=1, we_o=1, addr_o=0x20000010, wdata_o=0xDEADBEEF; tx returns 0x06.
- **Read with grant delay**: send 52 04 00 00 10 with rdata_i=0x12345678 and gnt_i delayed 5 cycles → req_o held stable for 6 cycles with we_o=0; tx returns 78 56 34 12.
- **Unknown command**: send 0x41 → tx returns 0x15, no req_o, busy_o back to 0 after the response.
- **Timeout**: send 57 10 00, then idle for 250 cycles, then 52 00 00 00 00 → no bus write; the read to 0x00000000 executes normally.
- **Line errors**: a 3-cycle low glitch on rx_pin produces no byte. A byte with the stop bit forced 0 produces no rx_valid and no parser advance.
- **Reset mid-packet**: assert rst during P_DATA → tx_pin=1 and req_o=0 next cycle, busy_o=0; a subsequent valid write completes correctly.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus command bridge: command/response
// codes, parser and receiver state encodings, and the bus request record.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_RESP} pstate_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Single-transfer bus between the bridge (master) and the arbiter (slave).
//   req_o/we_o/addr_o/wdata_o : request, held until gnt_i
//   gnt_i                     : transfer completes in the cycle req_o && gnt_i
//   rdata_i                   : read data, sampled in the grant cycle
interface uart_bus_bridge_if;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic [31:0] rdata_i;

  modport master (output req_o, we_o, addr_o, wdata_o, input gnt_i, rdata_i);
  modport slave  (input req_o, we_o, addr_o, wdata_o, output gnt_i, rdata_i);
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver.
//   clk, rst      : clock, synchronous active-low reset
//   rx_pin        : asynchronous serial input, idle high
//   div           : bit period minus one, in clk cycles
//   rx_valid      : 1-cycle pulse per correctly framed byte
//   rx_byte       : received byte, valid with rx_valid
module uart_byte_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  input  logic [15:0] div,
  output logic        rx_valid,
  output logic [7:0]  rx_byte
);
  import uart_bridge_pkg::*;

  rstate_t     st, st_n;
  logic        s0, s1, s_prev;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic        half_hit, bit_hit;

  assign half_hit = (cnt == (((div + 16'd1) >> 1) - 16'd1));
  assign bit_hit  = (cnt == div);
  assign rx_byte  = sh;

  always_comb begin
    st_n = st;
    case (st)
      R_IDLE:  if (s_prev && !s1) st_n = R_START;
      // start bit must still be low at half period, otherwise it was a glitch
      R_START: if (half_hit) st_n = s1 ? R_IDLE : R_DATA;
      R_DATA:  if (bit_hit && bit_idx == 3'd7) st_n = R_STOP;
      R_STOP:  if (bit_hit) st_n = R_IDLE;
      default: st_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0       <= 1'b1;
      s1       <= 1'b1;
      s_prev   <= 1'b1;
      st       <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
    end else begin
      s0       <= rx_pin;
      s1       <= s0;
      s_prev   <= s1;
      st       <= st_n;
      rx_valid <= 1'b0;
      // counter restarts on every state change and at each data-bit sample,
      // so samples land one bit period apart starting from mid start bit
      if (st != st_n || (st == R_DATA && bit_hit)) cnt <= '0;
      else                                        cnt <= cnt + 16'd1;
      if (st == R_START) bit_idx <= '0;
      if (st == R_DATA && bit_hit) begin
        sh      <= {s1, sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      // a low stop bit is a framing error: byte silently dropped
      if (st == R_STOP && bit_hit && s1) rx_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// UART command bridge acting as a bus master.
//   clk, rst : clock, synchronous active-low reset
//   rx_pin   : host command stream (8N1)
//   tx_pin   : response stream (8N1), idle high
//   busy_o   : high whenever the parser is not waiting for a command byte
//   bus      : master side of the single-transfer bus
// Packets: 57 a0 a1 a2 a3 d0 d1 d2 d3 (write, ACK 06), 52 a0 a1 a2 a3
// (read, 4 data bytes back), anything else gets NAK 15. Fields are LE.
module uart_bus_bridge #(
  parameter logic [15:0] BAUD_DIV = 16'd433,
  parameter logic [31:0] TIMEOUT  = 32'd5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_pin,
  output logic              tx_pin,
  output logic              busy_o,
  uart_bus_bridge_if.master bus
);
  import uart_bridge_pkg::*;

  logic       rx_valid;
  logic [7:0] rx_byte;

  uart_byte_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_pin   (rx_pin),
    .div      (BAUD_DIV),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte)
  );

  pstate_t     st, st_n;
  bus_req_t    breq;
  logic [1:0]  idx;
  logic [31:0] to_cnt;
  logic        to_hit;
  logic [23:0] resp_sh;
  logic [1:0]  resp_left;

  logic        tx_busy, tx_done, tx_load;
  logic [7:0]  tx_byte_n;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;

  // a byte arriving on the same cycle as expiry wins over the timeout
  assign to_hit  = (to_cnt == TIMEOUT - 32'd1) && !rx_valid;
  assign tx_done = tx_busy && (tx_cnt == BAUD_DIV) && (tx_bit == 4'd9);

  assign bus.req_o   = (st == P_BUS);
  assign bus.we_o    = breq.we;
  assign bus.addr_o  = breq.addr;
  assign bus.wdata_o = breq.wdata;
  assign busy_o      = (st != P_CMD);

  always_comb begin
    st_n      = st;
    tx_load   = 1'b0;
    tx_byte_n = 8'h00;
    case (st)
      P_CMD: if (rx_valid) begin
        if (rx_byte == CMD_WR || rx_byte == CMD_RD) st_n = P_ADDR;
        else begin
          st_n      = P_RESP;
          tx_load   = 1'b1;
          tx_byte_n = RSP_NAK;
        end
      end
      P_ADDR: begin
        if (rx_valid && idx == 2'd3) st_n = breq.we ? P_DATA : P_BUS;
        else if (to_hit)             st_n = P_CMD;
      end
      P_DATA: begin
        if (rx_valid && idx == 2'd3) st_n = P_BUS;
        else if (to_hit)             st_n = P_CMD;
      end
      // first response byte is loaded in the grant cycle so its start bit
      // goes out on the very next cycle
      P_BUS: if (bus.gnt_i) begin
        st_n      = P_RESP;
        tx_load   = 1'b1;
        tx_byte_n = breq.we ? RSP_ACK : bus.rdata_i[7:0];
      end
      P_RESP: if (tx_done) begin
        if (resp_left == 2'd0) st_n = P_CMD;
        else begin
          tx_load   = 1'b1;
          tx_byte_n = resp_sh[7:0];
        end
      end
      default: st_n = P_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= P_CMD;
      breq      <= '0;
      idx       <= '0;
      to_cnt    <= '0;
      resp_sh   <= '0;
      resp_left <= '0;
      tx_pin    <= 1'b1;
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
    end else begin
      st <= st_n;

      if (rx_valid || !(st == P_ADDR || st == P_DATA)) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 32'd1;

      if (st == P_CMD && rx_valid) begin
        breq.we   <= (rx_byte == CMD_WR);
        idx       <= '0;
        resp_left <= '0;
      end
      // idx wraps 3->0, so P_DATA starts counting from zero
      if (st == P_ADDR && rx_valid) begin
        breq.addr <= {rx_byte, breq.addr[31:8]};
        idx       <= idx + 2'd1;
      end
      if (st == P_DATA && rx_valid) begin
        breq.wdata <= {rx_byte, breq.wdata[31:8]};
        idx        <= idx + 2'd1;
      end
      if (st == P_BUS && bus.gnt_i) begin
        resp_sh   <= bus.rdata_i[31:8];
        resp_left <= breq.we ? 2'd0 : 2'd3;
      end
      if (st == P_RESP && tx_done && resp_left != 2'd0) begin
        resp_sh   <= {8'h00, resp_sh[23:8]};
        resp_left <= resp_left - 2'd1;
      end

      // serializer: tx_pin drives the start bit right after a load, then
      // shifts out {stop, data} one bit per BAUD_DIV+1 cycles
      if (tx_load) begin
        tx_pin  <= 1'b0;
        tx_sh   <= {1'b1, tx_byte_n};
        tx_cnt  <= '0;
        tx_bit  <= '0;
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == BAUD_DIV) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
          else begin
            tx_pin <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus
// transfers and response bytes; independent monitors decode the bus and the
// TX line and compare against the queues.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  localparam int BIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_pin = 1'b1;
  logic tx_pin, busy_o;

  uart_bus_bridge_if bif();

  always #5 clk = ~clk;

  uart_bus_bridge #(.BAUD_DIV(16'd7), .TIMEOUT(32'd200)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .tx_pin (tx_pin),
    .busy_o (busy_o),
    .bus    (bif)
  );

  int vectors = 0;
  int miscompares = 0;

  bus_req_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] pkt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h want none", name, act);
  endtask

  // ---------------- monitors ----------------
  logic [7:0] mon_b;
  always begin
    @(negedge clk);
    if (rst && tx_pin === 1'b0) begin
      repeat (BIT/2) @(negedge clk);
      if (tx_pin === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = tx_pin;
        end
        repeat (BIT) @(negedge clk);
        chk("tx_stop_bit", {31'd0, tx_pin}, 32'd1);
        if (exp_tx.size() == 0) flag("tx_unexpected_byte", {24'd0, mon_b});
        else                    chk("tx_byte", {24'd0, mon_b}, {24'd0, exp_tx.pop_front()});
      end
    end
  end

  bus_req_t mon_e;
  always @(negedge clk) begin
    if (rst && bif.req_o && bif.gnt_i) begin
      if (exp_bus.size() == 0) flag("bus_unexpected", bif.addr_o);
      else begin
        mon_e = exp_bus.pop_front();
        chk("bus_we",   {31'd0, bif.we_o}, {31'd0, mon_e.we});
        chk("bus_addr", bif.addr_o, mon_e.addr);
        if (mon_e.we) chk("bus_wdata", bif.wdata_o, mon_e.wdata);
      end
    end
  end

  // request run length and stability of the request fields while held
  int       req_run = 0;
  int       req_len_last = 0;
  logic     req_unstable = 1'b0;
  bus_req_t req_first;
  always @(negedge clk) begin
    if (!rst) req_run = 0;
    else if (bif.req_o) begin
      if (req_run == 0) req_first = {bif.we_o, bif.addr_o, bif.wdata_o};
      else if ({bif.we_o, bif.addr_o, bif.wdata_o} != req_first) req_unstable = 1'b1;
      req_run++;
    end else if (req_run != 0) begin
      req_len_last = req_run;
      req_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_pin = stop_v;
    repeat (BIT) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || busy_o !== 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) flag(name, n);
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bif.req_o !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag(name, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vectors ----------------
  initial begin
    bif.gnt_i   = 1'b1;
    bif.rdata_i = 32'h12345678;
    repeat (3) @(negedge clk);
    chk("rst_tx_pin", {31'd0, tx_pin},      32'd1);
    chk("rst_req",    {31'd0, bif.req_o},   32'd0);
    chk("rst_we",     {31'd0, bif.we_o},    32'd0);
    chk("rst_addr",   bif.addr_o,           32'd0);
    chk("rst_wdata",  bif.wdata_o,          32'd0);
    chk("rst_busy",   {31'd0, busy_o},      32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // write, grant tied high
    exp_bus.push_back('{we: 1'b1, addr: 32'h20000010, wdata: 32'hDEADBEEF});
    exp_tx.push_back(RSP_ACK);
    pkt = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_pkt();
    drain("wr_drain_timeout");
    chk("wr_req_cycles", req_len_last, 32'd1);

    // read, grant delayed 5 cycles
    bif.gnt_i = 1'b0;
    exp_bus.push_back('{we: 1'b0, addr: 32'h10000004, wdata: 32'h0});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    pkt = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h10};
    send_pkt();
    wait_req("rd_req_timeout");
    repeat (4) @(negedge clk);
    @(posedge clk); #1 bif.gnt_i = 1'b1;
    drain("rd_drain_timeout");
    chk("rd_req_cycles",   req_len_last, 32'd6);
    chk("rd_req_stable",   {31'd0, req_unstable}, 32'd0);

    // unknown command
    exp_tx.push_back(RSP_NAK);
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    chk("nak_busy_during", {31'd0, busy_o}, 32'd1);
    drain("nak_drain_timeout");
    chk("nak_busy_after", {31'd0, busy_o}, 32'd0);

    // timeout on a partial write, then a normal read
    pkt = '{8'h57, 8'h10, 8'h00};
    send_pkt();
    repeat (250) @(negedge clk);
    chk("to_busy_after", {31'd0, busy_o}, 32'd0);
    exp_bus.push_back('{we: 1'b0, addr: 32'h00000000, wdata: 32'h0});
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    pkt = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt();
    drain("to_rd_drain_timeout");

    // 3-cycle glitch: no byte
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_busy", {31'd0, busy_o}, 32'd0);

    // framing error: command byte with low stop bit is dropped
    send_byte(CMD_WR, 1'b0);
    repeat (20) @(negedge clk);
    chk("frame_err_busy", {31'd0, busy_o}, 32'd0);

    // reset in P_DATA, then a clean write
    pkt = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF};
    send_pkt();
    @(negedge clk);
    chk("mid_busy_before", {31'd0, busy_o}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_pin", {31'd0, tx_pin},    32'd1);
    chk("mid_rst_req",    {31'd0, bif.req_o}, 32'd0);
    chk("mid_rst_busy",   {31'd0, busy_o},    32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    exp_bus.push_back('{we: 1'b1, addr: 32'h00000100, wdata: 32'hCAFEF00D});
    exp_tx.push_back(RSP_ACK);
    pkt = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_pkt();
    drain("post_rst_drain_timeout");
    chk("post_rst_req_cycles", req_len_last, 32'd1);

    chk("leftover_bus", exp_bus.size(), 32'd0);
    chk("leftover_tx",  exp_tx.size(),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
